// File: rtl/spi_master_shift.sv
// SPI mode-0 shift engine: sends a parallel word MSB-first on MOSI and captures MISO,
// paced by the single-cycle rise/fall strobes of the SPI clock generator.
module spi_master_shift #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CNT_W-1:0]  len,
    input  logic              abort,
    output logic              clk_en,
    input  logic              spi_rise,
    input  logic              spi_fall,
    output logic              cs_n,
    output logic              sdo,
    input  logic              sdi,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   tx_reg_q, tx_reg_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [CNT_W-1:0]    idx_q, idx_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            tx_reg_q  <= '0;
            rx_data_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_reg_q  <= tx_reg_d;
            rx_data_q <= rx_data_d;
            idx_q     <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_reg_d  = tx_reg_q;
        rx_data_d = rx_data_q;
        idx_d     = idx_q;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    tx_reg_d  = tx_data;
                    idx_d     = len;
                    rx_data_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                // Abort wins over any strobe; partial rx_data is kept as-is.
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    if (spi_rise) begin
                        rx_data_d = {rx_data_q[DATA_W-2:0], sdi};
                    end
                    if (spi_fall) begin
                        if (idx_q == '0) begin
                            state_d = StDone;
                        end else begin
                            idx_d = idx_q - 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // All outputs decode straight from flops so an async reset clears them at once.
    assign start_ready = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign cs_n        = (state_q != StShift);
    assign clk_en      = (state_q == StShift);
    assign sdo         = (state_q == StShift) & tx_reg_q[idx_q];
    assign rx_valid    = (state_q == StDone);
    assign rx_data     = rx_data_q;

endmodule
